// File: rtl/microwire_read_ctrl.sv
// Microwire (93xx) READ engine: accepts one word-read request, runs the serial
// frame on CS/SK/DI/DO with a clock-divided SK, and returns the word with a framing flag.
module microwire_read_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int CMD_BITS  = 3 + ADDR_W;
  localparam int TOT_BITS  = CMD_BITS + DATA_W;
  localparam int BIT_CNT_W = $clog2(TOT_BITS + 1);

  localparam logic [7:0]           PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] CMD_LAST   = BIT_CNT_W'(CMD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] TOT_LAST   = BIT_CNT_W'(TOT_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE,
    S_TCS
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            phase_q, phase_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  err_q, err_d;
  logic [1:0]            sync_q, sync_d;
  logic                  cs_q, cs_d;
  logic                  sk_q, sk_d;
  logic                  di_q, di_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic phase_end;
  logic sample;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    err_d       = err_q;
    sync_d      = {sync_q[0], ee_do};
    cs_d        = cs_q;
    sk_d        = sk_q;
    di_d        = di_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    phase_end = (phase_q == PHASE_LAST);
    sample    = sync_q[1];

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_CMD;
          ready_d = 1'b0;
          cs_d    = 1'b1;
          sk_d    = 1'b0;
          di_d    = 1'b1;
          // cmd_q holds the bits still to send after the start bit on DI now
          cmd_d   = {2'b10, req_addr, 1'b0};
          phase_d = '0;
          bit_d   = '0;
        end
      end

      S_CMD, S_DATA: begin
        if (!phase_end) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = '0;
          if (!sk_q) begin
            sk_d = 1'b1;
          end else begin
            sk_d  = 1'b0;
            bit_d = bit_q + 1'b1;
            if (state_q == S_CMD) begin
              di_d  = cmd_q[CMD_BITS-1];
              cmd_d = cmd_q << 1;
              if (bit_q == CMD_LAST) begin
                // The device drives its dummy 0 during the last address bit.
                err_d   = sample;
                di_d    = 1'b0;
                state_d = S_DATA;
              end
            end else begin
              shift_d = {shift_q[DATA_W-2:0], sample};
              if (bit_q == TOT_LAST) begin
                state_d     = S_DONE;
                cs_d        = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = {shift_q[DATA_W-2:0], sample};
                rsp_err_d   = err_q;
              end
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_TCS;
        phase_d = '0;
        bit_d   = '0;
      end

      S_TCS: begin
        // Two CLK_DIV periods of deselect, bit_q[0] marks the second one.
        if (!phase_end) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = '0;
          if (bit_q[0]) begin
            bit_d   = '0;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the data/command shift registers are reset too; they are small, and this
  // keeps rsp_data at 0 after reset without a separate clear path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      sync_q      <= '0;
      cs_q        <= 1'b0;
      sk_q        <= 1'b0;
      di_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      sync_q      <= sync_d;
      cs_q        <= cs_d;
      sk_q        <= sk_d;
      di_q        <= di_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ee_cs     = cs_q;
  assign ee_sk     = sk_q;
  assign ee_di     = di_q;

endmodule

// File: tb/tb_microwire_read_ctrl.sv
// Bench for microwire_read_ctrl: two instances (default and ADDR_W=8/CLK_DIV=3),
// each talking to a behavioural 93xx EEPROM that decodes the command and returns mem[addr].
module tb_microwire_read_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        force_one = 1'b0;
  logic [7:0]  req_addr = '0;

  logic        ready_a, rsp_valid_a, rsp_err_a, cs_a, sk_a, di_a;
  logic        do_a = 1'b0;
  logic [15:0] rsp_data_a;
  logic        ready_b, rsp_valid_b, rsp_err_b, cs_b, sk_b, di_b;
  logic        do_b = 1'b0;
  logic [15:0] rsp_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [256];
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [8:0]  cmd_rx_a = '0;
  logic [10:0] cmd_rx_b = '0;

  always #5 clk = ~clk;

  microwire_read_ctrl u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(ready_a), .req_addr(req_addr[5:0]),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
    .ee_cs(cs_a), .ee_sk(sk_a), .ee_di(di_a), .ee_do(do_a)
  );

  microwire_read_ctrl #(.ADDR_W(8), .DATA_W(16), .CLK_DIV(3)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(ready_b), .req_addr(req_addr),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .ee_cs(cs_b), .ee_sk(sk_b), .ee_di(di_b), .ee_do(do_b)
  );

  logic        v_cs, v_sk, v_di, v_ready, v_rsp_valid, v_rsp_err;
  logic [15:0] v_rsp_data;
  logic [10:0] v_cmd_rx;
  assign v_cs        = sel ? cs_b        : cs_a;
  assign v_sk        = sel ? sk_b        : sk_a;
  assign v_di        = sel ? di_b        : di_a;
  assign v_ready     = sel ? ready_b     : ready_a;
  assign v_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign v_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
  assign v_rsp_data  = sel ? rsp_data_b  : rsp_data_a;
  assign v_cmd_rx    = sel ? cmd_rx_b    : {2'b00, cmd_rx_a};

  // Stream after the command: dummy 0, then the word MSB first.
  function automatic logic dev_bit(input logic [15:0] w, input int idx);
    if (idx < 1 || idx > 16) return 1'b0;
    return w[16-idx];
  endfunction

  always @(posedge sk_a) begin
    #1;
    if (cs_a) begin
      cnt_a++;
      if (cnt_a <= 9) cmd_rx_a = {cmd_rx_a[7:0], di_a};
      if (cnt_a >= 9) do_a = force_one ? 1'b1 : dev_bit(mem[{2'b00, cmd_rx_a[5:0]}], cnt_a - 9);
    end
  end
  always @(negedge cs_a) cnt_a = 0;

  always @(posedge sk_b) begin
    #1;
    if (cs_b) begin
      cnt_b++;
      if (cnt_b <= 11) cmd_rx_b = {cmd_rx_b[9:0], di_b};
      if (cnt_b >= 11) do_b = force_one ? 1'b1 : dev_bit(mem[cmd_rx_b[7:0]], cnt_b - 11);
    end
  end
  always @(negedge cs_b) cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},        32'(v_cs),        32'd0);
    check({tag, "_sk"},        32'(v_sk),        32'd0);
    check({tag, "_di"},        32'(v_di),        32'd0);
    check({tag, "_ready"},     32'(v_ready),     32'd1);
    check({tag, "_rsp_valid"}, 32'(v_rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(v_rsp_data),  32'd0);
    check({tag, "_rsp_err"},   32'(v_rsp_err),   32'd0);
  endtask

  // One read on the selected instance; starts and ends at a negedge.
  task automatic xact(input logic [7:0] addr, input logic hold, input logic [7:0] next_addr,
                      input int poke_cyc);
    int cyc, t_rsp, t_ready, n_rsp, runs_bad, run, rises, gap, cd, aw;
    int exp_rsp, exp_ready;
    logic prev_sk, e;
    logic [15:0] d, exp_data;
    cd = sel ? 3 : 4;
    aw = sel ? 8 : 6;
    exp_rsp   = 1 + (3 + aw + 16) * 2 * cd;
    exp_ready = exp_rsp + 2 * cd + 1;
    exp_data  = force_one ? 16'hFFFF : mem[addr];

    req_addr  = addr;
    req_valid = 1'b1;
    cyc = 0;
    while (!v_ready && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_wait", 32'(v_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    if (hold) req_addr = next_addr;
    else      req_valid = 1'b0;
    check("c1_cs",    32'(v_cs),    32'd1);
    check("c1_di",    32'(v_di),    32'd1);
    check("c1_ready", 32'(v_ready), 32'd0);

    t_rsp = 0; t_ready = 0; n_rsp = 0; runs_bad = 0; run = 0; rises = 0; gap = 0;
    prev_sk = 1'b0; d = '0; e = 1'b0;
    forever begin
      if (v_cs) begin
        if (v_sk == prev_sk) run++;
        else begin
          if (run != cd) runs_bad++;
          if (v_sk) rises++;
          run = 1;
        end
        prev_sk = v_sk;
      end
      if (v_rsp_valid) begin
        n_rsp++;
        if (t_rsp == 0) begin
          t_rsp = cyc;
          d = v_rsp_data;
          e = v_rsp_err;
        end
      end else if (t_rsp != 0 && !v_cs) begin
        gap++;
      end
      if (v_ready) t_ready = cyc;
      if (poke_cyc > 0 && cyc == poke_cyc) begin
        req_valid = 1'b1;
        req_addr  = 8'h11;
      end
      if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
        req_valid = 1'b0;
        req_addr  = addr;
      end
      if (t_ready != 0 || cyc >= 2000) break;
      @(negedge clk);
      cyc++;
    end

    check("t_rsp",     32'(t_rsp),   32'(exp_rsp));
    check("t_ready",   32'(t_ready), 32'(exp_ready));
    check("rsp_count", 32'(n_rsp),   32'd1);
    check("rsp_data",  32'(d),       32'(exp_data));
    check("rsp_err",   32'(e),       32'(force_one));
    check("rsp_hold",  32'(v_rsp_data), 32'(exp_data));
    check("cmd_bits",  32'(v_cmd_rx), (32'd6 << aw) | 32'(addr));
    check("sk_phase",  32'(runs_bad), 32'd0);
    check("sk_rises",  32'(rises),    32'(3 + aw + 16));
    check("cs_gap",    32'(gap),      32'(2 * cd + 1));
  endtask

  initial begin
    int cs_seen, rv_seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h2A] = 16'hBEEF;
    mem[8'hB7] = 16'h1234;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(v_ready), 32'd1);
    check("idle_cs",    32'(v_cs),    32'd0);

    // Basic read of 0xBEEF at 0x2A
    xact(8'h2A, 1'b0, 8'h00, 0);

    // Device absent / misframed: DO stuck high
    force_one = 1'b1;
    do_a      = 1'b1;
    xact(8'($urandom_range(0, 63)), 1'b0, 8'h00, 0);
    force_one = 1'b0;
    do_a      = 1'b0;

    // Back-to-back with req_valid held high
    xact(8'h00, 1'b1, 8'h3F, 0);
    xact(8'h3F, 1'b0, 8'h00, 0);

    // Request while busy (in CMD) must be dropped
    xact(8'($urandom_range(0, 63)), 1'b0, 8'h00, 20);
    cs_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (v_cs) cs_seen++;
    end
    check("no_extra_xact", 32'(cs_seen), 32'd0);

    // Reset while idle, asynchronous to the clock
    #3 rst = 1'b1;
    #1 check_reset_outputs("idle_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) xact(8'($urandom_range(0, 63)), 1'b0, 8'h00, 0);

    // Parameter sweep instance
    sel = 1'b1;
    @(negedge clk);
    xact(8'hB7, 1'b0, 8'h00, 0);
    for (int k = 0; k < 2; k++) xact(8'($urandom_range(0, 255)), 1'b0, 8'h00, 0);
    sel = 1'b0;
    @(negedge clk);

    // Reset in the middle of the DATA phase
    req_addr  = 8'h15;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (120) @(negedge clk);
    check("pre_rst_cs", 32'(v_cs), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("data_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs_seen = 0;
    rv_seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (v_cs) cs_seen++;
      if (v_rsp_valid) rv_seen++;
    end
    check("post_rst_cs",  32'(cs_seen), 32'd0);
    check("post_rst_rsp", 32'(rv_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
